// File: rtl/alarma_respuesta.sv
// Alarm response controller: ring, snooze and silence handling for an alarm clock.
// Rings on a rising match flag, beeps at 0.5 Hz and times out to a sticky "missed" flag.
module alarma_respuesta #(
    parameter logic [7:0]  COD_APAGAR   = 8'h5A,
    parameter logic [7:0]  COD_POSPONER = 8'h29,
    parameter int unsigned T_SONAR      = 60,
    parameter int unsigned T_POSPONER   = 300,
    parameter int unsigned MAX_POSP     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Flag_Pico,
    input  logic       Tick_1Hz,
    input  logic [7:0] Tecla,
    input  logic       Tecla_Valida,
    input  logic       Habilitar,
    output logic       Sonido,
    output logic [1:0] Estado_Alarma,
    output logic       Ack_Alarma,
    output logic       Perdida,
    output logic [1:0] Num_Posp
);

    localparam int unsigned TMAX = (T_SONAR > T_POSPONER) ? T_SONAR : T_POSPONER;
    localparam int unsigned CW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        StReposo    = 2'b00,
        StSonando   = 2'b01,
        StPospuesto = 2'b10
    } estado_e;

    estado_e         state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      num_q, num_d;
    logic            perd_q, perd_d;
    logic            ack_q, ack_d;
    logic            sonido_q, sonido_d;
    logic            prev_q;
    logic            primed_q;

    logic flag_nz;
    logic trigger;
    logic key_off;
    logic key_snooze;

    assign flag_nz    = |Flag_Pico;
    // primed_q suppresses a spurious edge on the first clock after reset release
    assign trigger    = primed_q & flag_nz & ~prev_q;
    assign key_off    = Tecla_Valida && (Tecla == COD_APAGAR);
    assign key_snooze = Tecla_Valida && (Tecla == COD_POSPONER);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        perd_d  = perd_q;
        ack_d   = 1'b0;
        if (!Habilitar) begin
            state_d = StReposo;
        end else begin
            case (state_q)
                StReposo: begin
                    if (trigger) begin
                        state_d = StSonando;
                        cnt_d   = '0;
                        num_d   = '0;
                        perd_d  = 1'b0;
                    end
                end
                StSonando: begin
                    if (key_off || (key_snooze && 32'(num_q) >= MAX_POSP)) begin
                        state_d = StReposo;
                        ack_d   = 1'b1;
                    end else if (key_snooze) begin
                        state_d = StPospuesto;
                        num_d   = num_q + 2'd1;
                        cnt_d   = '0;
                    end else if (Tick_1Hz) begin
                        if (cnt_q == CW'(T_SONAR - 1)) begin
                            state_d = StReposo;
                            perd_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StPospuesto: begin
                    if (key_off) begin
                        state_d = StReposo;
                        ack_d   = 1'b1;
                    end else if (trigger) begin
                        state_d = StSonando;
                        cnt_d   = '0;
                    end else if (Tick_1Hz) begin
                        if (cnt_q == CW'(T_POSPONER - 1)) begin
                            state_d = StSonando;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StReposo;
            endcase
        end
        sonido_d = (state_d == StSonando) && !cnt_d[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StReposo;
            cnt_q    <= '0;
            num_q    <= '0;
            perd_q   <= 1'b0;
            ack_q    <= 1'b0;
            sonido_q <= 1'b0;
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            perd_q   <= perd_d;
            ack_q    <= ack_d;
            sonido_q <= sonido_d;
            prev_q   <= flag_nz;
            primed_q <= 1'b1;
        end
    end

    assign Sonido        = sonido_q;
    assign Estado_Alarma = state_q;
    assign Ack_Alarma    = ack_q;
    assign Perdida       = perd_q;
    assign Num_Posp      = num_q;

endmodule

// File: tb/tb_alarma_respuesta.sv
// Randomized and directed bench for alarma_respuesta against a behavioural model.
module tb_alarma_respuesta;

    localparam int T_SONAR    = 60;
    localparam int T_POSPONER = 300;
    localparam int MAX_POSP   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Flag_Pico;
    logic       Tick_1Hz;
    logic [7:0] Tecla;
    logic       Tecla_Valida;
    logic       Habilitar;
    logic       Sonido;
    logic [1:0] Estado_Alarma;
    logic       Ack_Alarma;
    logic       Perdida;
    logic [1:0] Num_Posp;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model: mode 0 idle, 1 ringing, 2 snoozed; elapsed seconds in this phase
    int m_mode, m_secs, m_snoozes, m_missed, m_ack, m_prev, m_primed;

    alarma_respuesta dut (
        .clk          (clk),
        .reset        (reset),
        .Flag_Pico    (Flag_Pico),
        .Tick_1Hz     (Tick_1Hz),
        .Tecla        (Tecla),
        .Tecla_Valida (Tecla_Valida),
        .Habilitar    (Habilitar),
        .Sonido       (Sonido),
        .Estado_Alarma(Estado_Alarma),
        .Ack_Alarma   (Ack_Alarma),
        .Perdida      (Perdida),
        .Num_Posp     (Num_Posp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_secs = 0; m_snoozes = 0; m_missed = 0;
        m_ack = 0; m_prev = 0; m_primed = 0;
    endtask

    task automatic model_step();
        bit rise, off, snz;
        rise = m_primed && (Flag_Pico != 0) && !m_prev;
        m_prev = (Flag_Pico != 0);
        m_primed = 1;
        m_ack = 0;
        off = Tecla_Valida && Tecla == 8'h5A;
        snz = Tecla_Valida && Tecla == 8'h29;
        if (!Habilitar) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (rise) begin
                m_mode = 1; m_secs = 0; m_snoozes = 0; m_missed = 0;
            end
        end else if (m_mode == 1) begin
            if (off || (snz && m_snoozes == MAX_POSP)) begin
                m_mode = 0; m_ack = 1;
            end else if (snz) begin
                m_mode = 2; m_snoozes++; m_secs = 0;
            end else if (Tick_1Hz) begin
                m_secs++;
                if (m_secs == T_SONAR) begin
                    m_mode = 0; m_missed = 1;
                end
            end
        end else begin
            if (off) begin
                m_mode = 0; m_ack = 1;
            end else if (rise) begin
                m_mode = 1; m_secs = 0;
            end else if (Tick_1Hz) begin
                m_secs++;
                if (m_secs == T_POSPONER) begin
                    m_mode = 1; m_secs = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".estado"}, int'(Estado_Alarma), m_mode);
        check({tag, ".sonido"}, int'(Sonido), (m_mode == 1 && m_secs % 2 == 0) ? 1 : 0);
        check({tag, ".ack"}, int'(Ack_Alarma), m_ack);
        check({tag, ".perdida"}, int'(Perdida), m_missed);
        check({tag, ".num"}, int'(Num_Posp), m_snoozes);
    endtask

    task automatic step(input string tag, input int flag, input bit tick, input bit kv,
                        input logic [7:0] code, input bit hab);
        @(negedge clk);
        Flag_Pico = 8'(flag); Tick_1Hz = tick; Tecla_Valida = kv; Tecla = code;
        Habilitar = hab;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic ring(input string tag);
        step(tag, 0, 0, 0, 8'h00, 1);
        step(tag, 1, 0, 0, 8'h00, 1);
        check({tag, ".ringing"}, int'(Estado_Alarma), 1);
    endtask

    initial begin
        reset = 1'b0; Flag_Pico = 0; Tick_1Hz = 0; Tecla = 0; Tecla_Valida = 0; Habilitar = 0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Basic ring, beep toggling, silence
        ring("ring1");
        check("ring1.sonido_on", int'(Sonido), 1);
        for (int i = 0; i < 5; i++) step("beep", 1, 1, 0, 8'h00, 1);
        step("off", 1, 0, 1, 8'h5A, 1);
        check("off.ack", int'(Ack_Alarma), 1);
        step("off2", 1, 0, 0, 8'h00, 1);
        check("off2.ack_clear", int'(Ack_Alarma), 0);

        // Timeout after 60 ticks
        ring("ring2");
        for (int i = 0; i < T_SONAR; i++) step("timeout", 1, 1, 0, 8'h00, 1);
        check("timeout.perdida", int'(Perdida), 1);
        check("timeout.estado", int'(Estado_Alarma), 0);

        // Four snoozes: three accepted, fourth silences
        ring("ring3");
        for (int p = 0; p < 4; p++) begin
            step("snooze", 1, 0, 1, 8'h29, 1);
            if (p < 3) begin
                step("snz_ignored", 1, 0, 1, 8'h29, 1);
                for (int i = 0; i < T_POSPONER; i++) step("snz_wait", 1, 1, 0, 8'h00, 1);
                check("snooze.rering", int'(Estado_Alarma), 1);
            end
        end
        check("snooze4.ack", int'(Ack_Alarma), 1);

        // Key and tick on the same clock, then disable during snooze
        ring("ring4");
        step("tick", 1, 1, 0, 8'h00, 1);
        step("key_tick", 1, 1, 1, 8'h5A, 1);
        ring("ring5");
        step("other_key", 1, 0, 1, 8'h33, 1);
        step("no_valid", 1, 0, 0, 8'h5A, 1);
        step("snz", 1, 0, 1, 8'h29, 1);
        step("disable", 1, 0, 0, 8'h00, 0);
        check("disable.estado", int'(Estado_Alarma), 0);
        step("dis_trig0", 0, 0, 0, 8'h00, 0);
        step("dis_trig1", 1, 0, 0, 8'h00, 0);

        // Async reset mid-ring with flag held high
        ring("ring6");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) step("no_retrig", 1, 0, 0, 8'h00, 1);
        check("no_retrig.estado", int'(Estado_Alarma), 0);
        ring("retrig");

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            int flag;
            bit tick, kv, hab;
            logic [7:0] code;
            int r;
            flag = ($urandom_range(0, 29) == 0) ? ((Flag_Pico != 0) ? 0 : $urandom_range(1, 255))
                                                : int'(Flag_Pico);
            tick = ($urandom_range(0, 1) == 0);
            kv   = ($urandom_range(0, 59) == 0);
            r    = $urandom_range(0, 3);
            code = (r == 0) ? 8'h5A : (r == 1 || r == 2) ? 8'h29 : 8'($urandom);
            hab  = ($urandom_range(0, 299) != 0);
            step("rand", flag, tick, kv, code, hab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
